sensor_level_encoder: RTL
=========================

# sensor_level_encoder

Sequential front end that turns raw 8-bit sensor samples into the four 2-bit hazard levels: rain, seismic, wind and water level. These levels are the r1/r0, s1/s0, w1/w0 and l1/l0 inputs of the disaster-warning decision logic. Each channel is quantized against three thresholds, with hysteresis on the way down and a persistence filter before any level change. A watchdog forces a channel to level 00 and flags it stale if the channel stops reporting. All outputs are registered, so downstream combinational alert logic sees glitch-free levels.

## Interface
Parameters:
- DATA_W, 8, sample width
- TH1, 64, level 01 entry threshold
- TH2, 128, level 10 entry threshold
- TH3, 192, level 11 entry threshold
- HYST, 8, downward hysteresis margin; requires HYST <= TH1 and TH1 < TH2 < TH3
- PERSIST, 3, consecutive agreeing samples needed to change level; >= 1
- TIMEOUT, 1000, cycles without a sample before a channel goes stale; < 2^16

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- sample_valid  in  1  sample present
- sample_ready  out  1  sample accepted when valid & ready
- sample_ch  in  2  channel: 0 rain, 1 seismic, 2 wind, 3 water level
- sample_data  in  DATA_W  raw unsigned sample
- r1, r0  out  1 each  rain level (MSB, LSB)
- s1, s0  out  1 each  seismic level
- w1, w0  out  1 each  wind level
- l1, l0  out  1 each  water level
- stale  out  4  per-channel stale flag; bit index = channel
- level_change  out  1  one-cycle pulse when any level changed this cycle

## Operation
- Per channel state:
  - L: 2-bit output level
  - P: 2-bit pending level
  - C: persistence count
  - T: 16-bit idle timer
  - stale bit
- Accepted sample x on channel c:
  - U = number of k in {1,2,3} with x >= THk.
  - D = number of k with x >= THk - HYST (unsigned).
  - Candidate N = U if U > L; else D if D < L; else L.
- Persistence filter:
  - N == L: C <= 0.
  - N != L and N == P: C <= C+1.
  - N != L and N != P: P <= N, C <= 1.
  - When the updated C equals PERSIST: L <= P, C <= 0, level_change pulses. With PERSIST=1, the first differing sample updates L.
- Jumps of more than one level are allowed in a single update (e.g. 00 -> 11).
- Timer and stale:
  - T increments each cycle and saturates at TIMEOUT.
  - T clears on any accepted sample for that channel.
  - When T reaches TIMEOUT: L <= 00, C <= 0, stale <= 1. level_change pulses only if L was nonzero.
  - The next accepted sample on that channel clears stale and is filtered normally starting from L=00.
- A sample accepted in the same cycle a timer would reach TIMEOUT wins: no stale, T cleared.
- Channels are fully independent. Only the addressed channel's filter state changes on a sample.
- sample_ready is 0 during reset, then 1 from the first clk edge after rst_n deasserts; there is no back-pressure otherwise.

## Timing
- Reset values (asserted immediately, asynchronously):
  - all level outputs 0
  - stale = 4'b0000
  - level_change = 0
  - sample_ready = 0
  - all L, P, C, T = 0
- Latency: when a sample is accepted at edge n and completes persistence, the new level is visible after edge n+1. level_change is high for exactly that one cycle.
- A stale transition is visible on the edge where T reaches TIMEOUT.
- One sample per cycle maximum; back-to-back samples on the same channel are legal.
- Reset mid-operation discards all pending persistence and timer state.

## Test plan
Defaults unless stated: TH1=64, TH2=128, TH3=192, HYST=8, PERSIST=3, TIMEOUT=100.
- Rain samples 200, 200, 200 back-to-back -> r1r0 stays 00 through the first two samples, becomes 11 one cycle after the third, and level_change pulses once.
- Wind at 10; samples 124 ×3 -> stays 10 (inside hysteresis band). Then 119 ×3 -> wind becomes 01.
- Seismic samples 130, 130, 10, 130, 130, 130 -> s1s0 = 10 only after the sixth sample, with no change earlier.
- Water at 01; no water samples for 100 cycles -> l1l0 = 00, stale[3] = 1, and level_change pulses. The next water sample of 70 clears stale[3] and water returns to 01 after 3 samples.
- Interleaved rain 200 and wind 150, alternating ×6 -> rain goes to 11 and wind to 10, each on its own third sample, with no cross-talk.
- rst_n pulled low asynchronously mid-cycle with all levels nonzero -> all level outputs, stale and sample_ready go to 0 immediately. After release, 2 samples of 200 do not change the level (the count restarts from zero).

Source files
------------

// File: rtl/sensor_level_encoder_if.sv
// Sample bus between a sensor source and the level encoder.
interface sensor_level_encoder_if #(
  parameter int unsigned DATA_W = 8
);
  logic              sample_valid;
  logic              sample_ready;
  logic [1:0]        sample_ch;
  logic [DATA_W-1:0] sample_data;

  modport master (
    output sample_valid,
    output sample_ch,
    output sample_data,
    input  sample_ready
  );

  modport slave (
    input  sample_valid,
    input  sample_ch,
    input  sample_data,
    output sample_ready
  );
endinterface

// File: rtl/sensor_level_encoder.sv
// Quantizes raw sensor samples into four registered 2-bit hazard levels with
// downward hysteresis, a persistence filter and a per-channel staleness watchdog.
module sensor_level_encoder #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TH1     = 64,
  parameter int unsigned TH2     = 128,
  parameter int unsigned TH3     = 192,
  parameter int unsigned HYST    = 8,
  parameter int unsigned PERSIST = 3,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sensor_level_encoder_if.slave  smp,
  output logic                   r1,
  output logic                   r0,
  output logic                   s1,
  output logic                   s0,
  output logic                   w1,
  output logic                   w0,
  output logic                   l1,
  output logic                   l0,
  output logic [3:0]             stale,
  output logic                   level_change
);

  localparam int unsigned   CntW     = $clog2(PERSIST + 1);
  localparam logic [15:0]   TimeoutV = 16'(TIMEOUT);
  localparam logic [CntW-1:0] PersistV = CntW'(PERSIST);

  // Number of thresholds a..c that x meets or exceeds.
  function automatic logic [1:0] count_ge(input logic [DATA_W-1:0] x, input int unsigned a,
                                          input int unsigned b, input int unsigned c);
    logic [1:0] n;
    n = 2'd0;
    if (32'(x) >= a) n = n + 2'd1;
    if (32'(x) >= b) n = n + 2'd1;
    if (32'(x) >= c) n = n + 2'd1;
    return n;
  endfunction

  logic                    ready_q;
  logic                    smp_vld_q;
  logic [1:0]              smp_ch_q;
  logic [DATA_W-1:0]       smp_data_q;

  logic [3:0][1:0]         lvl_q, lvl_d;
  logic [3:0][1:0]         pend_q, pend_d;
  logic [3:0][CntW-1:0]    cnt_q, cnt_d;
  logic [3:0][15:0]        tmr_q, tmr_d;
  logic [3:0]              stale_q, stale_d;
  logic                    change_q, change_d;

  logic [1:0]              up_w, dn_w, cand;
  logic [CntW-1:0]         cnt_nxt;

  assign smp.sample_ready = ready_q;

  // Quantize the registered sample once; only one channel is addressed per cycle.
  assign up_w = count_ge(smp_data_q, TH1, TH2, TH3);
  assign dn_w = count_ge(smp_data_q, TH1 - HYST, TH2 - HYST, TH3 - HYST);

  // Register the accepted sample so the filter works from a clean, registered input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q    <= 1'b0;
      smp_vld_q  <= 1'b0;
      smp_ch_q   <= '0;
      smp_data_q <= '0;
    end else begin
      ready_q    <= 1'b1;
      smp_vld_q  <= smp.sample_valid & ready_q;
      smp_ch_q   <= smp.sample_ch;
      smp_data_q <= smp.sample_data;
    end
  end

  // Per-channel persistence filter and watchdog; a sample beats a timeout in the same cycle.
  always_comb begin
    lvl_d    = lvl_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    stale_d  = stale_q;
    change_d = 1'b0;
    cand     = 2'd0;
    cnt_nxt  = '0;
    for (int c = 0; c < 4; c++) begin
      if (smp_vld_q && (smp_ch_q == 2'(c))) begin
        tmr_d[c]   = '0;
        stale_d[c] = 1'b0;
        cand = (up_w > lvl_q[c]) ? up_w : ((dn_w < lvl_q[c]) ? dn_w : lvl_q[c]);
        if (cand == lvl_q[c]) begin
          cnt_d[c] = '0;
        end else begin
          if (cand == pend_q[c]) begin
            cnt_nxt = cnt_q[c] + CntW'(1);
          end else begin
            pend_d[c] = cand;
            cnt_nxt   = CntW'(1);
          end
          if (cnt_nxt == PersistV) begin
            lvl_d[c] = pend_d[c];
            cnt_d[c] = '0;
            change_d = 1'b1;
          end else begin
            cnt_d[c] = cnt_nxt;
          end
        end
      end else if (tmr_q[c] != TimeoutV) begin
        tmr_d[c] = tmr_q[c] + 16'd1;
        if (tmr_d[c] == TimeoutV) begin
          if (lvl_q[c] != 2'd0) change_d = 1'b1;
          lvl_d[c]   = 2'd0;
          cnt_d[c]   = '0;
          stale_d[c] = 1'b1;
        end
      end
    end
  end

  // Channel state registers; reset discards all pending filter and timer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q    <= '0;
      pend_q   <= '0;
      cnt_q    <= '0;
      tmr_q    <= '0;
      stale_q  <= '0;
      change_q <= 1'b0;
    end else begin
      lvl_q    <= lvl_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      stale_q  <= stale_d;
      change_q <= change_d;
    end
  end

  assign {r1, r0}     = lvl_q[0];
  assign {s1, s0}     = lvl_q[1];
  assign {w1, w0}     = lvl_q[2];
  assign {l1, l0}     = lvl_q[3];
  assign stale        = stale_q;
  assign level_change = change_q;

endmodule
